// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
// The optional FETCH_ALIGN_CHECK_EN macro is consumed by fetch_stage and
// fetch_next_pc; this package is the same in both builds.
package mips_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,  // request outstanding to instruction memory
        ST_HOLD  = 2'd1,  // IF_OUT holds a complete fetch, waiting for ID
        ST_DRAIN = 2'd2   // swallowing the ack of a cancelled request
    } fetch_state_t;

    // Boot vector (kseg1 ROM).
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Field layout of IF_OUT = {IR, PC}.
    localparam int IR_HI = 63;
    localparam int IR_LO = 32;
    localparam int PC_HI = 31;
    localparam int PC_LO = 0;

    // Clear the byte-offset bits so a PC always names a whole word.
    function automatic logic [31:0] force_word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch stage.
// Priority: cancel target, then a branch arriving this cycle, then a
// remembered (pending) branch, else the sequential pc+4 (wraps mod 2^32).
// Without FETCH_ALIGN_CHECK_EN the low two bits are forced to zero, so a
// misaligned target silently becomes the enclosing word.
module fetch_next_pc
    import mips_fetch_pkg::*;
(
    input  logic        cancel,
    input  logic [31:0] cancel_target,
    input  logic        jbr,
    input  logic [31:0] jbr_target,
    input  logic        pend,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic [31:0] raw_pc;

    // Pick the redirect source by priority, sequential by default.
    always_comb begin
        raw_pc = pc + 32'd4;
        if (cancel) begin
            raw_pc = cancel_target;
        end else if (jbr) begin
            raw_pc = jbr_target;
        end else if (pend) begin
            raw_pc = pend_target;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned targets are kept so the stage can flag them.
    assign next_pc = raw_pc;
`else
    // Misaligned targets are rounded down to a word boundary.
    assign next_pc = force_word_align(raw_pc);
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads, and presents
// {IR, PC} to the IF/ID register. Branches redirect after the delay slot,
// cancel redirects immediately and abandons any in-flight read.
// Optional macro FETCH_ALIGN_CHECK_EN: when defined, a misaligned PC is
// not fetched but handed to ID with PC_EXC_IF=1; when undefined, PCs are
// forced word-aligned and PC_EXC_IF is tied low.
//
// IF -> ID handshake: IF_over is "valid", ID_allow_in is "ready". A transfer
// happens on a clock edge where both are high. IF_over never depends on
// ID_allow_in, and while IF_over=1 and ID_allow_in=0, IF_OUT, IF_over and
// PC_EXC_IF stay unchanged. Only cancel (or reset) may withdraw IF_over.
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cancel,
    input  logic [31:0]  cancel_target,
    input  logic         jbr,
    input  logic [31:0]  jbr_target,
    input  logic         ID_allow_in,
    output logic         inst_req,
    output logic [31:0]  inst_addr,
    input  logic         inst_ack,
    input  logic [31:0]  inst_rdata,
    output logic         IF_over,
    output logic [63:0]  IF_OUT,
    output logic         PC_EXC_IF,
    output fetch_state_t dbg_state
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] BOOT_PC = RESET_PC;
`else
    localparam logic [31:0] BOOT_PC = force_word_align(RESET_PC);
`endif

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic        pend_q;
    logic [31:0] pend_target_q;
    logic        if_over_q;
    logic [63:0] if_out_q;
    logic        pc_exc_q;

    logic [31:0] next_pc;
    logic        misaligned;
    logic        req_live;
    logic        handoff;
    logic        capture_data;
    logic        capture_exc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign handoff      = if_over_q & ID_allow_in;
    assign capture_data = (state_q == ST_REQ) & ~misaligned & inst_ack;
    assign capture_exc  = (state_q == ST_REQ) & misaligned;

    fetch_next_pc u_next_pc (
        .cancel        (cancel),
        .cancel_target (cancel_target),
        .jbr           (jbr),
        .jbr_target    (jbr_target),
        .pend          (pend_q),
        .pend_target   (pend_target_q),
        .pc            (pc_q),
        .next_pc       (next_pc)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory request; cancel overrides the normal flow.
    always_comb begin
        state_d  = state_q;
        req_live = 1'b0;
        inst_req = 1'b0;
        if (state_q == ST_REQ && !misaligned) begin
            req_live = 1'b1;
            // Held low during reset so the first request follows reset release.
            inst_req = ~reset;
        end
        if (cancel) begin
            if (state_q == ST_DRAIN) begin
                // Still owed an ack from the earlier abandoned read.
                state_d = inst_ack ? ST_REQ : ST_DRAIN;
            end else if (req_live && !inst_ack) begin
                // A read is in flight; its ack must be swallowed.
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (misaligned || inst_ack) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (inst_ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // PC and branch-pending bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= BOOT_PC;
            pend_q        <= 1'b0;
            pend_target_q <= 32'b0;
        end else if (cancel) begin
            // Any branch seen alongside or before the cancel is discarded.
            pc_q   <= next_pc;
            pend_q <= 1'b0;
        end else if (handoff) begin
            // Delay slot (or plain instruction) leaves; move to its successor.
            pc_q   <= next_pc;
            pend_q <= 1'b0;
        end else if (jbr) begin
            // Delay slot not delivered yet: remember the target until it is.
            pend_q        <= 1'b1;
            pend_target_q <= jbr_target;
        end
    end

    // Output register toward IF/ID: capture on completion, drop on handoff/cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_over_q <= 1'b0;
            if_out_q  <= 64'b0;
            pc_exc_q  <= 1'b0;
        end else if (cancel || handoff) begin
            if_over_q <= 1'b0;
            pc_exc_q  <= 1'b0;
        end else if (capture_data) begin
            if_over_q              <= 1'b1;
            if_out_q[IR_HI:IR_LO] <= inst_rdata;
            if_out_q[PC_HI:PC_LO] <= pc_q;
            pc_exc_q               <= 1'b0;
        end else if (capture_exc) begin
            if_over_q              <= 1'b1;
            if_out_q[IR_HI:IR_LO] <= 32'b0;
            if_out_q[PC_HI:PC_LO] <= pc_q;
            pc_exc_q               <= 1'b1;
        end
    end

    assign inst_addr = pc_q;
    assign IF_over   = if_over_q;
    assign IF_OUT    = if_out_q;
    assign PC_EXC_IF = pc_exc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: memory responder with configurable latency,
// a transaction-level model of the expected program-order PC stream that
// is compared against the DUT every cycle, and directed scenarios with
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_fetch_stage;
    import mips_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         cancel;
    logic [31:0]  cancel_target;
    logic         jbr;
    logic [31:0]  jbr_target;
    logic         ID_allow_in;
    logic         inst_req;
    logic [31:0]  inst_addr;
    logic         inst_ack;
    logic [31:0]  inst_rdata;
    logic         IF_over;
    logic [63:0]  IF_OUT;
    logic         PC_EXC_IF;
    fetch_state_t dbg_state;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .cancel        (cancel),
        .cancel_target (cancel_target),
        .jbr           (jbr),
        .jbr_target    (jbr_target),
        .ID_allow_in   (ID_allow_in),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_ack      (inst_ack),
        .inst_rdata    (inst_rdata),
        .IF_over       (IF_over),
        .IF_OUT        (IF_OUT),
        .PC_EXC_IF     (PC_EXC_IF),
        .dbg_state     (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: boot word fixed, others a bijection of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [31:0] fix_pc(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    function automatic logic is_mis(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- memory responder (drives at negedge+1) ----------------
    int          mem_lat = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'b0;
    int          mem_cnt = 0;

    always @(negedge clk) begin
        #1;
        inst_ack   = 1'b0;
        inst_rdata = 32'hDEAD_BEEF;
        if (reset) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                inst_ack   = 1'b1;
                inst_rdata = mem_word(mem_addr);
                mem_busy   = 1'b0;
            end
        end else if (inst_req) begin
            if (mem_lat == 0) begin
                inst_ack   = 1'b1;
                inst_rdata = mem_word(inst_addr);
            end else begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = inst_addr;
            end
        end
    end

    // ---------------- model + per-cycle compare (negedge+2) ----------------
    logic [31:0] m_pc = 32'hBFC0_0000;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_t = 32'b0;
    logic        prev_hold = 1'b0;
    logic        prev_cancel = 1'b0;
    logic [63:0] prev_out = 64'b0;
    int          handoffs = 0;
    int          cyc = 0;
    int          last_handoff_cyc = 0;
    int          handoff_gap = 0;
    logic [31:0] last_handoff_pc = 32'b0;
    logic [31:0] last_handoff_ir = 32'b0;
    int          reqs_to_branch = 0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            m_pc        = fix_pc(32'hBFC0_0000);
            m_pend      = 1'b0;
            prev_hold   = 1'b0;
            prev_cancel = 1'b0;
        end else begin
            if (is_mis(m_pc)) begin
                check("no_req_misaligned", 64'(inst_req), 64'd0);
            end else if (inst_req) begin
                check("inst_addr", 64'(inst_addr), 64'(m_pc));
            end
            if (IF_over) begin
                check("if_out", IF_OUT, is_mis(m_pc) ? {32'b0, m_pc} : {mem_word(m_pc), m_pc});
                check("pc_exc", 64'(PC_EXC_IF), 64'(is_mis(m_pc)));
                check("req_in_hold", 64'(inst_req), 64'd0);
            end
            if (prev_hold) begin
                check("hold_over", 64'(IF_over), 64'd1);
                check("hold_out", IF_OUT, prev_out);
            end
            if (prev_cancel) begin
                check("over_after_cancel", 64'(IF_over), 64'd0);
            end
            if (inst_req && inst_addr == 32'h8000_0100) reqs_to_branch++;

            prev_hold   = IF_over && !ID_allow_in && !cancel;
            prev_out    = IF_OUT;
            prev_cancel = cancel;

            if (cancel) begin
                m_pc   = fix_pc(cancel_target);
                m_pend = 1'b0;
            end else if (IF_over && ID_allow_in) begin
                handoffs++;
                handoff_gap      = cyc - last_handoff_cyc;
                last_handoff_cyc = cyc;
                last_handoff_pc  = IF_OUT[31:0];
                last_handoff_ir  = IF_OUT[63:32];
                if (jbr)         m_pc = fix_pc(jbr_target);
                else if (m_pend) m_pc = fix_pc(m_pend_t);
                else             m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end else if (jbr) begin
                m_pend   = 1'b1;
                m_pend_t = jbr_target;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at negedge (#0) of the first cycle with reset low.
    task automatic do_reset(input int lat, input logic allow);
        reset       = 1'b1;
        cancel      = 1'b0;
        jbr         = 1'b0;
        ID_allow_in = allow;
        mem_lat     = lat;
        repeat (3) @(negedge clk);
        #3;
        check("rst_if_over", 64'(IF_over), 64'd0);
        check("rst_if_out", IF_OUT, 64'd0);
        check("rst_pc_exc", 64'(PC_EXC_IF), 64'd0);
        check("rst_inst_req", 64'(inst_req), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_handoffs(input int n, input int budget);
        int start;
        int k;
        start = handoffs;
        k = 0;
        while (handoffs < start + n && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (handoffs < start + n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_handoffs: got %0d expected %0d", handoffs - start, n);
        end
    endtask

    task automatic wait_req(input int budget);
        int k;
        k = 0;
        #3;
        while (!inst_req && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!inst_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: got 0 expected 1");
        end
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input int budget);
        int k;
        k = 0;
        #3;
        while (!(inst_req && inst_addr == a) && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!(inst_req && inst_addr == a)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req_addr: got %h expected %h", inst_addr, a);
        end
    endtask

    task automatic wait_if_over(input int budget);
        int k;
        k = 0;
        #3;
        while (!IF_over && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!IF_over) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_if_over: got 0 expected 1");
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int h0;
        int r0;
        reset         = 1'b1;
        cancel        = 1'b0;
        cancel_target = 32'b0;
        jbr           = 1'b0;
        jbr_target    = 32'b0;
        ID_allow_in   = 1'b1;
        inst_ack      = 1'b0;
        inst_rdata    = 32'b0;

        // Reset release, zero-wait first fetch, then steady-state throughput.
        do_reset(0, 1'b1);
        #3;
        check("first_req", 64'(inst_req), 64'd1);
        check("first_addr", 64'(inst_addr), 64'hBFC0_0000);
        @(negedge clk); #3;
        check("first_over", 64'(IF_over), 64'd1);
        check("first_out", IF_OUT, 64'h2408_0001_BFC0_0000);
        @(negedge clk); #3;
        check("second_addr", 64'(inst_addr), 64'hBFC0_0004);
        wait_handoffs(4, 20);
        check("throughput_gap", 64'(handoff_gap), 64'd2);

        // Backpressure: five stalled cycles then exactly one handoff.
        do_reset(0, 1'b0);
        wait_if_over(10);
        for (int i = 0; i < 5; i++) begin
            check("bp_req", 64'(inst_req), 64'd0);
            check("bp_over", 64'(IF_over), 64'd1);
            check("bp_out", IF_OUT, 64'h2408_0001_BFC0_0000);
            if (i < 4) begin
                @(negedge clk); #3;
            end
        end
        @(negedge clk);
        ID_allow_in = 1'b1;
        h0 = handoffs;
        #3;
        check("bp_one_handoff", 64'(handoffs - h0), 64'd1);
        @(negedge clk); #3;
        check("bp_next_addr", 64'(inst_addr), 64'hBFC0_0004);

        // Branch while the delay slot is still being fetched.
        do_reset(2, 1'b1);
        wait_req_addr(32'hBFC0_0008, 40);
        @(negedge clk);
        jbr = 1'b1;
        jbr_target = 32'h8000_0100;
        @(negedge clk);
        jbr = 1'b0;
        wait_handoffs(1, 20);
        check("delay_slot_pc", 64'(last_handoff_pc), 64'hBFC0_0008);
        wait_handoffs(1, 20);
        check("branch_pc", 64'(last_handoff_pc), 64'h8000_0100);

        // Cancel during an outstanding read; stale ack lands 3 cycles after request.
        do_reset(3, 1'b1);
        @(negedge clk);
        cancel = 1'b1;
        cancel_target = 32'hBFC0_0380;
        @(negedge clk);
        cancel = 1'b0;
        mem_lat = 0;
        wait_req(20);
        check("cancel_req_addr", 64'(inst_addr), 64'hBFC0_0380);
        wait_handoffs(1, 20);
        check("cancel_handoff_pc", 64'(last_handoff_pc), 64'hBFC0_0380);
        check("cancel_handoff_ir", 64'(last_handoff_ir), 64'hA625_1A65);

        // Branch to a misaligned target, taken right at a handoff.
        do_reset(0, 1'b0);
        wait_if_over(10);
        @(negedge clk);
        jbr = 1'b1;
        jbr_target = 32'h8000_0102;
        ID_allow_in = 1'b1;
        @(negedge clk);
        jbr = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        ID_allow_in = 1'b0;
        #3;
        check("mis_no_req", 64'(inst_req), 64'd0);
        @(negedge clk); #3;
        check("mis_out", IF_OUT, 64'h0000_0000_8000_0102);
        check("mis_exc", 64'(PC_EXC_IF), 64'd1);
        @(negedge clk);
        cancel = 1'b1;
        cancel_target = 32'hBFC0_0380;
        @(negedge clk);
        cancel = 1'b0;
        ID_allow_in = 1'b1;
        wait_handoffs(1, 20);
        check("mis_recover_pc", 64'(last_handoff_pc), 64'hBFC0_0380);
`else
        #3;
        check("mis_req", 64'(inst_req), 64'd1);
        check("mis_forced_addr", 64'(inst_addr), 64'h8000_0100);
        wait_handoffs(1, 20);
        check("mis_forced_pc", 64'(last_handoff_pc), 64'h8000_0100);
`endif

        // Cancel and branch together: cancel wins, branch never fetched.
        do_reset(2, 1'b1);
        r0 = reqs_to_branch;
        @(negedge clk);
        cancel = 1'b1;
        cancel_target = 32'hBFC0_0380;
        jbr = 1'b1;
        jbr_target = 32'h8000_0100;
        @(negedge clk);
        cancel = 1'b0;
        jbr = 1'b0;
        wait_handoffs(1, 30);
        check("cj_first_pc", 64'(last_handoff_pc), 64'hBFC0_0380);
        wait_handoffs(1, 30);
        check("cj_second_pc", 64'(last_handoff_pc), 64'hBFC0_0384);
        check("cj_no_branch_req", 64'(reqs_to_branch - r0), 64'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if a scenario wedges despite the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
